reg_wb_arbiter: RTL and testbench
=================================

// Module: reg_wb_arbiter
// PURPOSE
//  Shares the register file's single write port between two writeback producers: req0 = ALU result, req1 = load data.
//  Round-robin arbitration; the winner is registered onto the write port, so the port can take one write per cycle.
//  Keeps a per-register pending-write scoreboard, fed by issue and drained by commit, for read-after-write hazard checks.
//  Sits between the execute/memory stages and reg_file.
// PARAMETERS
//  DATA_W    32  width of the write data
//  ADDR_W    4   register address width
//  NUM_REGS  16  number of architectural registers (2**ADDR_W)
//  CNT_W     2   width of each pending counter; max in-flight writes per register = 2**CNT_W-1
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       synchronous, active-high reset
//  req0_valid   in   1       ALU writeback request
//  req0_addr    in   ADDR_W  ALU destination register
//  req0_data    in   DATA_W  ALU result
//  req0_ready   out  1       req0 granted this cycle
//  req1_valid   in   1       load writeback request
//  req1_addr    in   ADDR_W  load destination register
//  req1_data    in   DATA_W  load data
//  req1_ready   out  1       req1 granted this cycle
//  issue_valid  in   1       an instruction with a register destination issues
//  issue_dest   in   ADDR_W  destination of the issuing instruction
//  issue_ready  out  1       0 when the counter for issue_dest is saturated (issue must stall)
//  chk_addr1    in   ADDR_W  hazard-check source 1
//  chk_addr2    in   ADDR_W  hazard-check source 2
//  busy1        out  1       pending count of chk_addr1 != 0 (combinational)
//  busy2        out  1       pending count of chk_addr2 != 0 (combinational)
//  wb_en        out  1       drives write_enable1 of reg_file
//  wb_addr      out  ADDR_W  drives write_addr
//  wb_data      out  DATA_W  drives write_data
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - wb_en=0, wb_addr=0, wb_data=0.
//   - All pending counters = 0; RR pointer = favour req0.
//   - Reset mid-operation discards in-flight and unissued writes with no commit.
//  Handshake:
//   - A transfer occurs when reqN_valid && reqN_ready in the same cycle.
//   - readyN is combinational from both valid inputs and the RR pointer.
//   - At most one ready is high per cycle.
//   - A requester holds valid, addr and data stable until it sees ready.
//  Arbitration:
//   - Only one valid: that one is granted.
//   - Both valid: grant the requester opposite the last grant.
//   - Pointer updates only on a grant.
//   - Neither valid: no ready, pointer unchanged.
//  Output stage:
//   - wb_en/addr/data register the granted request; latency 1 cycle.
//   - The output stage never back-pressures, so throughput is 1 write per cycle.
//   - wb_en=0 in any cycle after no grant; wb_addr and wb_data then hold.
//  Scoreboard:
//   - cnt[r] +1 on issue_valid && issue_ready with issue_dest=r.
//   - cnt[r] -1 on a registered commit (wb_en=1) to r.
//   - Both events on the same r in one cycle: unchanged.
//   - issue_ready = (cnt[issue_dest] != 2**CNT_W-1); no wrap is possible.
//   - A commit to a register with cnt=0 (a write with no issue) leaves it 0.
//   - busy is computed from the current counters; a commit clears busy in the cycle after wb_en.
// STRUCTURE
//  Package reg_wb_pkg holds:
//   - DATA_W/ADDR_W/NUM_REGS/CNT_W defaults.
//   - typedef wb_req_t {addr, data}.
//   - enum req_id_e {REQ_ALU=0, REQ_LOAD=1}.
//  Sub-module rr_arb2 contains the 2-way round-robin grant and pointer.
//  Top level contains the output register and the NUM_REGS x CNT_W counter array.
// TESTING
//  1 Reset, then req0 valid: addr=3, data=0xDEADBEEF.
//    -> req0_ready=1 same cycle.
//    -> next cycle wb_en=1, wb_addr=3, wb_data=0xDEADBEEF.
//  2 Both valid for 4 cycles (req0 addr=1, req1 addr=2).
//    -> grants alternate 0,1,0,1 and wb_addr sequence is 1,2,1,2.
//    -> the losing requester keeps its data stable and it is written exactly once.
//  3 Issue dest=5 three times.
//    -> busy1 (chk_addr1=5) = 1 and issue_ready=0 for dest 5.
//    -> after three commits to 5, busy1=0.
//  4 Same cycle: issue dest=7 and wb_en commit to 7, with cnt[7]=1.
//    -> cnt stays 1 and busy stays 1.
//  5 rst asserted while req1 is valid and cnt[4]=2.
//    -> next cycle wb_en=0, all busy=0, and the RR pointer favours req0.
//  6 No valid for 3 cycles.
//    -> wb_en=0 and wb_addr/wb_data hold their last values.

Source files
------------

// File: rtl/reg_wb_pkg.sv
// Shared widths, writeback request type and requester identifiers for the
// register-file writeback arbiter.
package reg_wb_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;
  localparam int CNT_W    = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    REQ_ALU  = 1'b0,
    REQ_LOAD = 1'b1
  } req_id_e;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Bus bundle between the execute/memory stages and the writeback arbiter:
// two writeback requesters, issue tracking, hazard checks and the write port.
interface reg_wb_arbiter_if #(
  parameter int DATA_W = reg_wb_pkg::DATA_W,
  parameter int ADDR_W = reg_wb_pkg::ADDR_W
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_dest;
  logic              issue_ready;
  logic [ADDR_W-1:0] chk_addr1;
  logic [ADDR_W-1:0] chk_addr2;
  logic              busy1;
  logic              busy2;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    output issue_valid, issue_dest,
    input  issue_ready,
    output chk_addr1, chk_addr2,
    input  busy1, busy2,
    input  wb_en, wb_addr, wb_data
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    input  issue_valid, issue_dest,
    output issue_ready,
    input  chk_addr1, chk_addr2,
    output busy1, busy2,
    output wb_en, wb_addr, wb_data
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner.
//  state    | meaning
//  REQ_ALU  | req0 won last; req1 wins a tie
//  REQ_LOAD | req1 won last (or reset); req0 wins a tie
module rr_arb2
  import reg_wb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

  req_id_e last_q, last_d;

  always_ff @(posedge clk) begin
    if (rst) last_q <= REQ_LOAD;
    else     last_q <= last_d;
  end

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    last_d = last_q;
    if (valid0 && valid1) begin
      if (last_q == REQ_ALU) grant1 = 1'b1;
      else                   grant0 = 1'b1;
    end else if (valid0) begin
      grant0 = 1'b1;
    end else if (valid1) begin
      grant1 = 1'b1;
    end
    if (grant0)      last_d = REQ_ALU;
    else if (grant1) last_d = REQ_LOAD;
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the register file write port between ALU and load writeback and
// tracks pending writes per register for read-after-write hazard checks.
module reg_wb_arbiter
  import reg_wb_pkg::*;
#(
  parameter int DATA_W   = reg_wb_pkg::DATA_W,
  parameter int ADDR_W   = reg_wb_pkg::ADDR_W,
  parameter int NUM_REGS = reg_wb_pkg::NUM_REGS,
  parameter int CNT_W    = reg_wb_pkg::CNT_W
) (
  input logic              clk,
  input logic              rst,
  reg_wb_arbiter_if.slave  bus
);

  logic              grant0, grant1;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  always_comb begin
    win_addr = bus.req0_addr;
    win_data = bus.req0_data;
    if (grant1) begin
      win_addr = bus.req1_addr;
      win_data = bus.req1_data;
    end
  end

  // Address/data hold when nothing is granted so the port stays quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wb_en   <= 1'b0;
      bus.wb_addr <= '0;
      bus.wb_data <= '0;
    end else begin
      bus.wb_en <= grant0 | grant1;
      if (grant0 | grant1) begin
        bus.wb_addr <= win_addr;
        bus.wb_data <= win_data;
      end
    end
  end

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            cnt_up, cnt_dn;
  logic                           issue_fire;

  assign bus.issue_ready = (cnt[bus.issue_dest] != {CNT_W{1'b1}});
  assign issue_fire      = bus.issue_valid && bus.issue_ready;
  assign bus.busy1       = (cnt[bus.chk_addr1] != '0);
  assign bus.busy2       = (cnt[bus.chk_addr2] != '0);

  // A commit to an idle register is a write with no issue; it must not wrap.
  always_comb begin
    cnt_up = '0;
    cnt_dn = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_up[r] = issue_fire && (bus.issue_dest == ADDR_W'(r));
      cnt_dn[r] = bus.wb_en && (bus.wb_addr == ADDR_W'(r)) && (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (cnt_up[r] && !cnt_dn[r])      cnt[r] <= cnt[r] + CNT_W'(1);
        else if (cnt_dn[r] && !cnt_up[r]) cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: expected grants and writes are queued by
// the stimulus and popped by an independent negedge monitor.
module tb_reg_wb_arbiter;
  import reg_wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  req_id_e grant_q[$];
  wb_req_t wb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input req_id_e id, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_req_t w;
    w.addr = a;
    w.data = d;
    grant_q.push_back(id);
    wb_q.push_back(w);
  endtask

  // Monitor: every grant and every write-port pulse must match the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req0_ready && bus.req1_ready)
        chk("one_ready", 2'b11, 2'b01);
      if (bus.req0_ready || bus.req1_ready) begin
        if (grant_q.size() == 0) begin
          chk("unexpected_grant", {63'd0, bus.req1_ready}, 64'hFF);
        end else begin
          req_id_e e;
          e = grant_q.pop_front();
          chk("grant_id", {63'd0, bus.req1_ready}, {63'd0, e == REQ_LOAD});
        end
      end
      if (bus.wb_en) begin
        if (wb_q.size() == 0) begin
          chk("unexpected_wb", {60'd0, bus.wb_addr}, 64'hFF);
        end else begin
          wb_req_t w;
          w = wb_q.pop_front();
          chk("wb_addr", 64'(bus.wb_addr), 64'(w.addr));
          chk("wb_data", 64'(bus.wb_data), 64'(w.data));
        end
      end
    end
  end

  logic [DATA_W-1:0] a_dat [2];
  logic [DATA_W-1:0] b_dat [2];
  int i0, i1;
  logic g0, g1;

  initial begin
    bus.req0_valid = 0; bus.req0_addr = 0; bus.req0_data = 0;
    bus.req1_valid = 0; bus.req1_addr = 0; bus.req1_data = 0;
    bus.issue_valid = 0; bus.issue_dest = 0;
    bus.chk_addr1 = 0; bus.chk_addr2 = 0;
    tick(); tick();
    rst = 0;
    @(negedge clk);
    chk("rst_wb_en", 64'(bus.wb_en), 64'd0);
    chk("rst_wb_addr", 64'(bus.wb_addr), 64'd0);
    chk("rst_wb_data", 64'(bus.wb_data), 64'd0);
    chk("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
    chk("rst_busy1", 64'(bus.busy1), 64'd0);

    // 1: single ALU write
    tick();
    bus.req0_valid = 1; bus.req0_addr = 4'd3; bus.req0_data = 32'hDEADBEEF;
    push_wr(REQ_ALU, 4'd3, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_ready0", 64'(bus.req0_ready), 64'd1);
    chk("t1_ready1", 64'(bus.req1_ready), 64'd0);
    tick();
    bus.req0_valid = 0;
    @(negedge clk);
    chk("t1_wb_en", 64'(bus.wb_en), 64'd1);

    // 2: both requesters busy, pointer fresh from reset
    tick();
    rst = 1;
    tick();
    rst = 0;
    a_dat[0] = 32'hA000_0000; a_dat[1] = 32'hA000_0001;
    b_dat[0] = 32'hB000_0000; b_dat[1] = 32'hB000_0001;
    push_wr(REQ_ALU,  4'd1, a_dat[0]);
    push_wr(REQ_LOAD, 4'd2, b_dat[0]);
    push_wr(REQ_ALU,  4'd1, a_dat[1]);
    push_wr(REQ_LOAD, 4'd2, b_dat[1]);
    i0 = 0; i1 = 0;
    for (int cyc = 0; cyc < 8 && (i0 < 2 || i1 < 2); cyc++) begin
      bus.req0_valid = (i0 < 2); bus.req0_addr = 4'd1;
      bus.req0_data  = (i0 < 2) ? a_dat[i0 < 2 ? i0 : 0] : '0;
      bus.req1_valid = (i1 < 2); bus.req1_addr = 4'd2;
      bus.req1_data  = (i1 < 2) ? b_dat[i1 < 2 ? i1 : 0] : '0;
      @(negedge clk);
      g0 = bus.req0_ready; g1 = bus.req1_ready;
      tick();
      if (g0) i0++;
      if (g1) i1++;
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    chk("t2_all_granted", 64'(i0 + i1), 64'd4);
    tick();

    // 3: saturate register 5, then drain it with three commits
    bus.issue_valid = 1; bus.issue_dest = 4'd5;
    tick(); tick(); tick();
    bus.issue_valid = 0;
    bus.chk_addr1 = 4'd5;
    @(negedge clk);
    chk("t3_busy1_set", 64'(bus.busy1), 64'd1);
    chk("t3_issue_stall", 64'(bus.issue_ready), 64'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      bus.req0_valid = 1; bus.req0_addr = 4'd5; bus.req0_data = 32'h55 + 32'(k);
      push_wr(REQ_ALU, 4'd5, 32'h55 + 32'(k));
      tick();
    end
    bus.req0_valid = 0;
    @(negedge clk);
    chk("t3_busy1_last", 64'(bus.busy1), 64'd1);
    tick();
    @(negedge clk);
    chk("t3_busy1_clear", 64'(bus.busy1), 64'd0);
    chk("t3_issue_free", 64'(bus.issue_ready), 64'd1);

    // 4: issue and commit to register 7 in the same cycle
    tick();
    bus.issue_valid = 1; bus.issue_dest = 4'd7;
    tick();
    bus.issue_valid = 0;
    bus.chk_addr2 = 4'd7;
    bus.req0_valid = 1; bus.req0_addr = 4'd7; bus.req0_data = 32'h77;
    push_wr(REQ_ALU, 4'd7, 32'h77);
    tick();
    bus.req0_valid = 0;
    bus.issue_valid = 1; bus.issue_dest = 4'd7;
    @(negedge clk);
    chk("t4_issue_ready", 64'(bus.issue_ready), 64'd1);
    tick();
    bus.issue_valid = 0;
    @(negedge clk);
    chk("t4_busy2_held", 64'(bus.busy2), 64'd1);
    tick();
    bus.req0_valid = 1; bus.req0_addr = 4'd7; bus.req0_data = 32'h78;
    push_wr(REQ_ALU, 4'd7, 32'h78);
    tick();
    bus.req0_valid = 0;
    tick();
    @(negedge clk);
    chk("t4_busy2_clear", 64'(bus.busy2), 64'd0);

    // 5: reset with a load pending and two writes outstanding on register 4
    tick();
    bus.issue_valid = 1; bus.issue_dest = 4'd4;
    tick(); tick();
    bus.issue_valid = 0;
    bus.chk_addr1 = 4'd4;
    @(negedge clk);
    chk("t5_busy1_pre", 64'(bus.busy1), 64'd1);
    tick();
    bus.req1_valid = 1; bus.req1_addr = 4'd9; bus.req1_data = 32'h99;
    rst = 1;
    tick();
    rst = 0;
    bus.req1_valid = 0;
    @(negedge clk);
    chk("t5_wb_en", 64'(bus.wb_en), 64'd0);
    chk("t5_busy1", 64'(bus.busy1), 64'd0);
    chk("t5_busy2", 64'(bus.busy2), 64'd0);
    tick();
    bus.req0_valid = 1; bus.req0_addr = 4'hA; bus.req0_data = 32'hA0A0;
    bus.req1_valid = 1; bus.req1_addr = 4'hB; bus.req1_data = 32'hB0B0;
    push_wr(REQ_ALU, 4'hA, 32'hA0A0);
    @(negedge clk);
    chk("t5_ptr_ready0", 64'(bus.req0_ready), 64'd1);
    tick();
    bus.req0_valid = 0; bus.req1_valid = 0;
    tick();

    // 6: idle port holds its last address and data
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_wb_en", 64'(bus.wb_en), 64'd0);
      chk("t6_wb_addr", 64'(bus.wb_addr), 64'hA);
      chk("t6_wb_data", 64'(bus.wb_data), 64'hA0A0);
      tick();
    end

    chk("grant_q_drained", 64'(grant_q.size()), 64'd0);
    chk("wb_q_drained", 64'(wb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
